// File: rtl/jedro_1_dram_arbiter.sv
// Round-robin arbiter that shares the single-port data RAM between the core
// load/store port (0) and a loader/debug port (1), with a response timeout.
module jedro_1_dram_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s0_stb,
  input  logic [DATA_WIDTH/8-1:0] s0_we,
  input  logic [ADDR_WIDTH-1:0]   s0_addr,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic                    s0_ack,
  output logic                    s0_err,
  input  logic                    s1_stb,
  input  logic [DATA_WIDTH/8-1:0] s1_we,
  input  logic [ADDR_WIDTH-1:0]   s1_addr,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic                    s1_ack,
  output logic                    s1_err,
  output logic                    m_stb,
  output logic [DATA_WIDTH/8-1:0] m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_ack,
  input  logic                    m_err,
  output logic                    busy_o,
  output logic                    gnt_o
);

  localparam int WE_W = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             last_grant_r;
  logic             pick_s;
  logic             timeout_s;
  logic             done_s;
  logic             done_err_s;

  // Round-robin choice: a tie goes to the port that was not granted last.
  always_comb begin
    pick_s = 1'b0;
    if (s0_stb && s1_stb) begin
      pick_s = ~last_grant_r;
    end else if (s1_stb) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Timeout fires on the last allowed wait cycle without a response.
  always_comb begin
    timeout_s = 1'b0;
    if (TIMEOUT_EN) begin
      timeout_s = (cnt_r == CNT_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Completion decode; m_err beats m_ack, and only ISSUE/WAIT listen to the memory.
  always_comb begin
    done_s     = 1'b0;
    done_err_s = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        done_s     = m_ack | m_err;
        done_err_s = m_err;
      end
      ST_WAIT: begin
        done_s     = m_ack | m_err | timeout_s;
        done_err_s = m_err | ~m_ack;
      end
      default: begin
        done_s     = 1'b0;
        done_err_s = 1'b0;
      end
    endcase
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      last_grant_r <= 1'b1;
      gnt_o        <= 1'b0;
      busy_o       <= 1'b0;
      m_stb        <= 1'b0;
      m_we         <= '0;
      m_addr       <= '0;
      m_wdata      <= '0;
      s0_rdata     <= '0;
      s0_ack       <= 1'b0;
      s0_err       <= 1'b0;
      s1_rdata     <= '0;
      s1_ack       <= 1'b0;
      s1_err       <= 1'b0;
    end else begin
      s0_ack <= 1'b0;
      s0_err <= 1'b0;
      s1_ack <= 1'b0;
      s1_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (s0_stb || s1_stb) begin
            state_r      <= ST_ISSUE;
            gnt_o        <= pick_s;
            last_grant_r <= pick_s;
            busy_o       <= 1'b1;
            m_stb        <= 1'b1;
            cnt_r        <= '0;
            m_we         <= pick_s ? s1_we    : s0_we;
            m_addr       <= pick_s ? s1_addr  : s0_addr;
            m_wdata      <= pick_s ? s1_wdata : s0_wdata;
          end else begin
            busy_o <= 1'b0;
          end
        end
        ST_ISSUE: begin
          m_stb   <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
      // A completion overrides the per-state next state and routes the response.
      if (done_s) begin
        state_r <= ST_DONE;
        if (gnt_o) begin
          s1_ack <= ~done_err_s;
          s1_err <= done_err_s;
          if (!done_err_s) begin
            s1_rdata <= m_rdata;
          end
        end else begin
          s0_ack <= ~done_err_s;
          s0_err <= done_err_s;
          if (!done_err_s) begin
            s0_rdata <= m_rdata;
          end
        end
      end
    end
  end

  logic [WE_W-1:0] unused_we_s;
  assign unused_we_s = '0;

endmodule

// File: tb/tb_jedro_1_dram_arbiter.sv
// Directed self-checking bench for jedro_1_dram_arbiter.
module tb_jedro_1_dram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s0_stb, s1_stb;
  logic [3:0]  s0_we, s1_we, m_we;
  logic [31:0] s0_addr, s1_addr, m_addr;
  logic [31:0] s0_wdata, s1_wdata, m_wdata;
  logic [31:0] s0_rdata, s1_rdata, m_rdata;
  logic        s0_ack, s0_err, s1_ack, s1_err;
  logic        m_stb, m_ack, m_err, busy_o, gnt_o;

  int checks = 0;
  int errors = 0;

  jedro_1_dram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s0_stb(s0_stb), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_rdata(s0_rdata), .s0_ack(s0_ack), .s0_err(s0_err),
    .s1_stb(s1_stb), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_rdata(s1_rdata), .s1_ack(s1_ack), .s1_err(s1_err),
    .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .busy_o(busy_o), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] exp_addr [4];
  logic [31:0] mem_word;
  int n;
  logic ack_seen;

  initial begin
    exp_addr[0] = 32'h0000_0100;
    exp_addr[1] = 32'h0000_0200;
    exp_addr[2] = 32'h0000_0104;
    exp_addr[3] = 32'h0000_0204;
    rst_i = 1'b1;
    s0_stb = 1'b0; s0_we = 4'h0; s0_addr = 32'h0; s0_wdata = 32'h0;
    s1_stb = 1'b0; s1_we = 4'h0; s1_addr = 32'h0; s1_wdata = 32'h0;
    m_rdata = 32'h0; m_ack = 1'b0; m_err = 1'b0;
    step(); step();
    rst_i = 1'b0;
    chk("rst_m_stb", {63'd0, m_stb}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_gnt", {63'd0, gnt_o}, 64'd0);
    chk("rst_acks", {60'd0, s0_ack, s0_err, s1_ack, s1_err}, 64'd0);

    // Test 1: port 0 write
    s0_stb = 1'b1; s0_we = 4'hF; s0_addr = 32'h10; s0_wdata = 32'hDEAD_BEEF;
    mem_word = 32'hDEAD_BEEF;
    step();
    chk("t1_m_stb", {63'd0, m_stb}, 64'd1);
    chk("t1_m_fields", {m_we, m_addr, m_wdata[27:0]}, {4'hF, 32'h10, 28'hEAD_BEEF});
    chk("t1_gnt", {63'd0, gnt_o}, 64'd0);
    step();
    chk("t1_m_stb_pulse", {63'd0, m_stb}, 64'd0);
    m_ack = 1'b1; m_rdata = 32'h0;
    step();
    m_ack = 1'b0;
    chk("t1_s0_ack", {63'd0, s0_ack}, 64'd1);
    chk("t1_other", {61'd0, s0_err, s1_ack, s1_err}, 64'd0);
    s0_stb = 1'b0; s0_we = 4'h0;
    step();
    chk("t1_busy_c4", {63'd0, busy_o}, 64'd0);
    chk("t1_s0_ack_pulse", {63'd0, s0_ack}, 64'd0);

    // Test 2: port 1 read-back
    s1_stb = 1'b1; s1_we = 4'h0; s1_addr = 32'h10;
    step();
    chk("t2_m_stb", {63'd0, m_stb}, 64'd1);
    chk("t2_fields", {28'd0, m_we, m_addr}, {28'd0, 4'h0, 32'h10});
    chk("t2_gnt", {63'd0, gnt_o}, 64'd1);
    step();
    m_ack = 1'b1; m_rdata = mem_word;
    step();
    m_ack = 1'b0; m_rdata = 32'h0;
    chk("t2_s1_ack", {63'd0, s1_ack}, 64'd1);
    chk("t2_s1_rdata", {32'd0, s1_rdata}, 64'hDEAD_BEEF);
    chk("t2_s0_quiet", {30'd0, s0_rdata, s0_ack, s0_err}, 64'd0);
    s1_stb = 1'b0;
    step();

    // Test 3: both ports held, alternating grants
    s0_stb = 1'b1; s0_addr = 32'h100;
    s1_stb = 1'b1; s1_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_m_stb", {63'd0, m_stb}, 64'd1);
      chk("t3_gnt", {63'd0, gnt_o}, 64'(k % 2));
      chk("t3_addr", {32'd0, m_addr}, {32'd0, exp_addr[k]});
      step();
      chk("t3_m_stb_low1", {63'd0, m_stb}, 64'd0);
      m_ack = 1'b1; m_rdata = 32'hA000_0000 + 32'(k);
      step();
      m_ack = 1'b0;
      chk("t3_m_stb_low2", {63'd0, m_stb}, 64'd0);
      if (k % 2 == 0) begin
        chk("t3_acks_p0", {60'd0, s0_ack, s0_err, s1_ack, s1_err}, 64'b1000);
        chk("t3_rdata_p0", {32'd0, s0_rdata}, 64'hA000_0000 + 64'(k));
        if (k < 2) s0_addr = 32'h104; else s0_stb = 1'b0;
      end else begin
        chk("t3_acks_p1", {60'd0, s0_ack, s0_err, s1_ack, s1_err}, 64'b0010);
        chk("t3_rdata_p1", {32'd0, s1_rdata}, 64'hA000_0000 + 64'(k));
        if (k < 2) s1_addr = 32'h204; else s1_stb = 1'b0;
      end
      step();
      chk("t3_m_stb_low3", {63'd0, m_stb}, 64'd0);
    end
    chk("t3_idle", {63'd0, busy_o}, 64'd0);

    // Test 4: timeout, then a late ack in IDLE
    s0_stb = 1'b1; s0_addr = 32'h40;
    step();
    chk("t4_m_stb", {63'd0, m_stb}, 64'd1);
    n = 0; ack_seen = 1'b0;
    while (n < 40 && !s0_err) begin
      step();
      n++;
      if (s0_ack || s1_ack || s1_err) ack_seen = 1'b1;
    end
    chk("t4_err_delay", 64'(n), 64'd17);
    chk("t4_err", {63'd0, s0_err}, 64'd1);
    chk("t4_no_ack", {63'd0, ack_seen}, 64'd0);
    s0_stb = 1'b0;
    repeat (5) step();
    m_ack = 1'b1; m_rdata = 32'h1234_5678;
    step();
    m_ack = 1'b0;
    chk("t4_late_ignored", {60'd0, s0_ack, s0_err, busy_o, m_stb}, 64'd0);
    chk("t4_rdata_kept", {32'd0, s0_rdata}, 64'hA000_0002);
    s1_stb = 1'b1; s1_addr = 32'h44;
    step();
    chk("t4_next_stb", {63'd0, m_stb}, 64'd1);
    step();
    m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
    step();
    m_ack = 1'b0;
    chk("t4_next_ack", {31'd0, s1_ack, s1_rdata}, {31'd0, 1'b1, 32'hCAFE_0001});
    s1_stb = 1'b0;
    step();

    // Test 5: m_err beats m_ack
    s0_stb = 1'b1; s0_addr = 32'h48;
    step();
    step();
    m_ack = 1'b1; m_err = 1'b1; m_rdata = 32'h5555_5555;
    step();
    m_ack = 1'b0; m_err = 1'b0;
    chk("t5_err_ack", {62'd0, s0_err, s0_ack}, 64'b10);
    chk("t5_rdata_kept", {32'd0, s0_rdata}, 64'hA000_0002);
    s0_stb = 1'b0;
    step();

    // Test 6: reset during WAIT
    s0_stb = 1'b1; s0_addr = 32'h4C;
    step();
    step();
    step();
    rst_i = 1'b1; s0_stb = 1'b0;
    step();
    rst_i = 1'b0;
    chk("t6_outs", {59'd0, m_stb, busy_o, gnt_o, s0_ack, s0_err}, 64'd0);
    chk("t6_bus", {m_addr, m_wdata}, 64'd0);
    chk("t6_rdata", {s0_rdata, s1_rdata}, 64'd0);
    m_ack = 1'b1; m_rdata = 32'h7777_7777;
    step();
    m_ack = 1'b0;
    chk("t6_late", {60'd0, s0_ack, s0_err, s1_ack, busy_o}, 64'd0);
    s0_stb = 1'b1; s0_addr = 32'h50;
    s1_stb = 1'b1; s1_addr = 32'h60;
    step();
    chk("t6_gnt", {62'd0, m_stb, gnt_o}, 64'b10);
    chk("t6_addr", {32'd0, m_addr}, 64'h50);
    step();
    m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
    step();
    m_ack = 1'b0;
    chk("t6_ack", {62'd0, s0_ack, s1_ack}, 64'b10);
    s0_stb = 1'b0; s1_stb = 1'b0;
    step();
    chk("t6_idle", {63'd0, busy_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jedro_1_dram_arbiter.md
Name: jedro_1_dram_arbiter

Overview:
Two-requester arbiter placed in front of the single-port byte-write data RAM (stb/we/addr/wdata/rdata/ack/err bus). Port 0 serves the core load/store path. Port 1 serves a loader/debug master. The block forwards one transaction at a time, chooses between the ports round-robin, routes the response back to the granted requester, and generates a bus error if the memory does not respond within a bounded time.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; the width of each `we` field is DATA_WIDTH/8
TIMEOUT_CYCLES, 16, response-wait limit in cycles; 0 disables the timeout

Ports:
clk_i  in  1  clock; all logic is rising-edge
rst_i  in  1  synchronous reset, active-high
s0_stb  in  1  port 0 request; held high until s0_ack or s0_err
s0_we  in  DATA_WIDTH/8  port 0 byte write enables; all zero means read
s0_addr  in  ADDR_WIDTH  port 0 address
s0_wdata  in  DATA_WIDTH  port 0 write data
s0_rdata  out  DATA_WIDTH  port 0 read data, valid with s0_ack
s0_ack  out  1  port 0 completion, one-cycle pulse
s0_err  out  1  port 0 error, one-cycle pulse
s1_stb, s1_we, s1_addr, s1_wdata, s1_rdata, s1_ack, s1_err: same as port 0, for port 1
m_stb  out  1  memory request, one-cycle pulse per transaction
m_we  out  DATA_WIDTH/8  forwarded byte enables
m_addr  out  ADDR_WIDTH  forwarded address
m_wdata  out  DATA_WIDTH  forwarded write data
m_rdata  in  DATA_WIDTH  memory read data
m_ack  in  1  memory completion
m_err  in  1  memory error
busy_o  out  1  high in every state other than IDLE
gnt_o  out  1  index of the current or last granted port

Behaviour:
- Reset values (rst_i high at an edge): state=IDLE. All outputs are 0, except last_grant=1, so port 0 wins the first tie. The timeout counter is 0.
- IDLE:
  - If any sX_stb is high, select the port, latch its we/addr/wdata into m_*, and go to ISSUE.
  - Only one port requesting: grant that port. Both requesting: grant the port that is not last_grant.
  - Set last_grant=gnt_o at the moment of grant.
- ISSUE (1 cycle):
  - m_stb=1 and the timeout counter is 0.
  - Go to WAIT. If m_ack or m_err is sampled high at the end of this cycle, go directly to DONE.
- WAIT:
  - m_stb=0; m_we/m_addr/m_wdata are held stable.
  - The counter increments on each cycle with no response.
  - m_err high: go to DONE with error. m_err wins if m_ack and m_err are high together.
  - Else m_ack high: go to DONE with success, capturing m_rdata.
  - Else, if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1: go to DONE with error.
- DONE (1 cycle):
  - Exactly one of ack or err pulses to the granted port, and never to the other port.
  - sX_rdata updates only on successful ack and holds its value otherwise.
  - Always return to IDLE next.
- Requester obligation: drop stb by the edge following its ack/err cycle, or keep it high only to issue a new request.
  - The IDLE cycle after DONE samples stb afresh, so back-to-back requests are legal.
  - Minimum spacing between m_stb pulses is 4 cycles.
- Latency: request seen at cycle 0, m_stb at cycle 1; m_ack at cycle 2 gives sX_ack at cycle 3, and IDLE at cycle 4.
- m_ack/m_err arriving in IDLE or DONE, including a late response after timeout, is ignored.
- A request changing its fields while stalled is not re-sampled. The latched copy is used.
- Reset mid-transaction:
  - The transaction is abandoned and no ack/err is returned.
  - A memory response arriving after reset is ignored.
  - last_grant returns to 1.

Test Plan:
1. Port 0 single write: s0 we=4'hF, addr=0x10, wdata=0xDEADBEEF; RAM acks 1 cycle after stb -> m_stb exactly 1 cycle at cycle 1 with the same fields; s0_ack at cycle 3; s1_ack never asserted; busy_o is 0 at cycle 4.
2. Read-back on port 1: s1 we=0, addr=0x10 after test 1 -> s1_rdata=0xDEADBEEF together with s1_ack; s0_* outputs stay 0.
3. Simultaneous requests, both held repeatedly for 4 transactions, each with a distinct address -> grant order 0,1,0,1 (gnt_o), each ack goes only to its own port, and m_stb pulses are 4 cycles apart.
4. Timeout: memory never acks, TIMEOUT_CYCLES=16 -> s0_err one pulse at 17 cycles after m_stb, no s0_ack; a late m_ack 5 cycles later is ignored and the next request proceeds normally.
5. Error precedence: m_ack and m_err asserted in the same cycle -> s0_err=1, s0_ack=0, s0_rdata unchanged.
6. Reset mid-WAIT: rst_i for 1 cycle while waiting -> all outputs 0, no ack/err pulse, a later m_ack is ignored; the next simultaneous request is granted to port 0.
